// File: rtl/width_gearbox.sv
// Stream width converter with a unit-granular shift buffer and per-unit keep.
// Define WIDTH_GEARBOX_BIG_ENDIAN_EN for MSB-first unit packing on both sides.
module width_gearbox #(
  parameter int ISIZE = 24,
  parameter int OSIZE = 32,
  parameter int USIZE = 8
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [ISIZE-1:0]         wr_data,
  input  logic [ISIZE/USIZE-1:0]   wr_keep,
  input  logic                     wr_vld,
  output logic                     wr_ready,
  input  logic                     wr_last,
  output logic [OSIZE-1:0]         rd_data,
  output logic [OSIZE/USIZE-1:0]   rd_keep,
  output logic                     rd_vld,
  input  logic                     rd_ready,
  output logic                     rd_last
);
  localparam int IU = ISIZE / USIZE;
  localparam int OU = OSIZE / USIZE;
  localparam int BU = IU + OU;
  localparam int BW = BU * USIZE;
  localparam int FW = $clog2(BU + 1);
`ifdef WIDTH_GEARBOX_BIG_ENDIAN_EN
  localparam bit BIG_END = 1'b1;
`else
  localparam bit BIG_END = 1'b0;
`endif

  if ((ISIZE % USIZE) != 0 || (OSIZE % USIZE) != 0) begin : g_size_check
    $error("width_gearbox: ISIZE and OSIZE must be multiples of USIZE");
  end

  // Unit 0 of the buffer lives in mem_q[USIZE-1:0]; units at or above fill are always zero.
  logic [BW-1:0]    mem_q, mem_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             last_pend_q, last_pend_d;
  logic             live_q;
  logic [ISIZE-1:0] wr_lin;
  logic [IU-1:0]    keep_lin;
  logic             wr_fire, rd_fire;
  int               fill_i, n_add, n_take, base;

  assign fill_i   = int'(fill_q);
  assign wr_ready = live_q && !last_pend_q && (fill_i + IU <= BU);
  assign rd_vld   = (fill_i >= OU) || last_pend_q;
  assign rd_last  = last_pend_q && (fill_i <= OU);
  assign wr_fire  = wr_vld && wr_ready;
  assign rd_fire  = rd_vld && rd_ready;

  always_comb begin : in_map
    wr_lin   = '0;
    keep_lin = '0;
    n_add    = 0;
    for (int k = 0; k < IU; k++) begin
      if (BIG_END) keep_lin[k] = wr_keep[IU-1-k];
      else         keep_lin[k] = wr_keep[k];
      if (keep_lin[k]) begin
        n_add = n_add + 1;
        if (BIG_END) wr_lin[k*USIZE +: USIZE] = wr_data[(IU-1-k)*USIZE +: USIZE];
        else         wr_lin[k*USIZE +: USIZE] = wr_data[k*USIZE +: USIZE];
      end
    end
  end

  // The read shift happens first; the write then lands at the post-shift fill level.
  always_comb begin : next_state
    n_take = 0;
    if (rd_fire) n_take = (fill_i < OU) ? fill_i : OU;
    base        = fill_i - n_take;
    mem_d       = mem_q >> (n_take * USIZE);
    fill_d      = FW'(base);
    last_pend_d = last_pend_q;
    if (rd_fire && rd_last) last_pend_d = 1'b0;
    if (wr_fire) begin
      mem_d  = mem_d | (BW'(wr_lin) << (base * USIZE));
      fill_d = FW'(base + n_add);
      if (wr_last) last_pend_d = 1'b1;
    end
  end

  always_comb begin : out_map
    rd_data = '0;
    rd_keep = '0;
    for (int j = 0; j < OU; j++) begin
      if (j < fill_i) begin
        if (BIG_END) begin
          rd_data[(OU-1-j)*USIZE +: USIZE] = mem_q[j*USIZE +: USIZE];
          rd_keep[OU-1-j]                  = 1'b1;
        end else begin
          rd_data[j*USIZE +: USIZE] = mem_q[j*USIZE +: USIZE];
          rd_keep[j]                = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mem_q       <= '0;
      fill_q      <= '0;
      last_pend_q <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      fill_q      <= fill_d;
      last_pend_q <= last_pend_d;
      live_q      <= 1'b1;
    end
  end
endmodule

// File: doc/width_gearbox.md
Name: width_gearbox

Overview:
- Generalised stream width converter for arbitrary input/output widths, including non-integer ratios such as 24->32 and 32->24.
- Both widths must be multiples of a common unit USIZE.
- Repacks a valid/ready stream through an internal unit-granular shift buffer, with per-unit keep on input and output so packets may end on any unit.
- Sits between packet sources and sinks of unequal width, e.g. an I2C byte stream feeding a 24- or 32-bit register path.

Parameters:
- ISIZE, 24, input data width in bits; must be a multiple of USIZE.
- OSIZE, 32, output data width in bits; must be a multiple of USIZE.
- USIZE, 8, unit (lane) width in bits; IU=ISIZE/USIZE, OU=OSIZE/USIZE; elaboration error if either division has a remainder.

Ports:
- clock  input  1  single clock for all logic
- rst_n  input  1  asynchronous active-low reset
- wr_data  input  ISIZE  input word; unit 0 in bits [USIZE-1:0]
- wr_keep  input  IU  valid units; contiguous from bit 0; all ones unless wr_last
- wr_vld  input  1  input valid
- wr_ready  output  1  input ready
- wr_last  input  1  final word of packet
- rd_data  output  OSIZE  output word; invalid units driven 0
- rd_keep  output  OU  valid units of rd_data, contiguous from bit 0
- rd_vld  output  1  output valid
- rd_ready  input  1  output ready
- rd_last  output  1  final word of packet

Behaviour:
- Clock and reset: one clock, `clock`; reset `rst_n` is asynchronous and active-low.
- Buffer:
  - Capacity BU = IU+OU units; `fill` counter of width $clog2(BU+1); flag `last_pend`.
  - Reset: fill=0, last_pend=0, buffer contents 0.
  - Reset outputs: wr_ready=0 while rst_n low, 1 on the first edge after release; rd_vld=0, rd_last=0, rd_keep=0, rd_data=0.
- wr_ready: registered-state only, no combinational path from rd_ready. wr_ready = !last_pend && (fill+IU <= BU).
- Write (wr_vld && wr_ready):
  - Append popcount(wr_keep) units at position fill, after any read shift in the same cycle.
  - If wr_last, set last_pend.
- Output:
  - rd_vld = (fill >= OU) || last_pend.
  - rd_data/rd_keep come from buffer units 0..min(fill,OU)-1; unused units are 0.
  - rd_last = last_pend && (fill <= OU).
- Read (rd_vld && rd_ready):
  - Shift the buffer down by min(fill,OU) units.
  - If rd_last, clear last_pend.
- Simultaneous read and write: fill_next = fill - taken + added. The write lands after the shift.
- Latency: data accepted at edge N is visible on rd_* after edge N (earliest rd_vld cycle N+1). No fall-through.
- Zero-length packet:
  - wr_last with wr_keep=0 and fill=0 produces one beat with rd_keep=0, rd_last=1.
  - wr_keep=0 without wr_last is illegal; the write is accepted and adds nothing.
- Packet boundary: after wr_last is accepted, no further input is taken until the final output beat drains, so packets never share an output word.
- Stability: rd_* must hold stable while rd_vld && !rd_ready.
- Reset mid-packet: all state clears immediately; any partial packet is discarded.
- ISIZE==OSIZE: the same logic applies; one-cycle registered passthrough.

Optional Feature:
- Macro WIDTH_GEARBOX_BIG_ENDIAN_EN.
- Defined: unit 0 maps to the most significant unit of wr_data and rd_data. rd_keep is MSB-aligned: bit OU-1 is the first unit. wr_keep is likewise MSB-contiguous.
- Undefined: little-endian packing as described above.

Test Plan:
- ISIZE=24, OSIZE=32, USIZE=8. Four writes of bytes 0x01..0x0C with last on the 4th, rd_ready=1 -> rd_data 0x04030201, 0x08070605, 0x0C0B0A09; rd_keep=F each; rd_last on the 3rd beat only.
- Two writes 0x030201, 0x060504 with last -> 0x04030201 keep=F, then 0x00000605 keep=3 rd_last=1.
- rd_ready=0, continuous wr_vld -> two words accepted (fill=6), wr_ready=0 from then; rd_vld=1 with rd_data=0x04030201 held stable. Releasing rd_ready resumes flow with no loss or duplication.
- Zero-length packet (wr_keep=0, wr_last=1) into an empty block -> exactly one beat rd_keep=0, rd_last=1, rd_data=0; wr_ready=0 until it is consumed.
- ISIZE=32, OSIZE=24: one write 0x0C0B0A09 keep=F, last -> 0x0B0A09 keep=7, then 0x00000C keep=1 rd_last=1.
- Reset asserted mid-packet with fill=5 -> rd_vld=0 and rd_keep=0 asynchronously. After release, a new packet of 0x030201, 0x060504 (last) produces the same output as the second scenario, with no stale bytes.
